// File: rtl/fetch_unit.sv
// Instruction-byte prefetch stage: issues single-byte memory reads,
// buffers returned bytes in a small FIFO and presents the head byte.
module fetch_unit #(
  parameter int BYTE_SIZE = 8,
  parameter int WORD_SIZE = 16,
  parameter int DEPTH = 4,
  parameter logic [WORD_SIZE-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 mem_req,
  output logic [WORD_SIZE-1:0] mem_addr,
  input  logic                 mem_ack,
  input  logic [BYTE_SIZE-1:0] mem_data,
  input  logic                 read_en,
  output logic [BYTE_SIZE-1:0] ext_data_bus,
  output logic                 byte_valid,
  output logic                 stall,
  input  logic                 flush,
  input  logic [WORD_SIZE-1:0] flush_addr,
  output logic [WORD_SIZE-1:0] pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_e;

  state_e state_q, state_d;
  logic [WORD_SIZE-1:0] fetch_q, fetch_d;
  logic [WORD_SIZE-1:0] req_addr_q, req_addr_d;
  logic [WORD_SIZE-1:0] pc_q, pc_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_pop;
  logic [BYTE_SIZE-1:0] fifo_q [DEPTH];
  logic [BYTE_SIZE-1:0] fifo_d [DEPTH];
  logic pop, push;

  // Free space is judged after this cycle's pop so a full FIFO
  // being drained can re-issue without a bubble.
  always_comb begin
    pop = read_en & (cnt_q != '0) & ~flush;
    push = (state_q == REQ) & mem_ack & ~flush;
    cnt_pop = cnt_q - CW'(pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (!flush && cnt_pop < FULL) state_d = REQ;
      end
      REQ: begin
        if (flush)        state_d = mem_ack ? IDLE : DISCARD;
        else if (mem_ack) state_d = (cnt_d < FULL) ? REQ : IDLE;
      end
      DISCARD: begin
        if (mem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req = (state_q != IDLE);
    mem_addr = (state_q == DISCARD) ? req_addr_q : fetch_q;
    byte_valid = (cnt_q != '0);
    ext_data_bus = byte_valid ? fifo_q[rd_q] : '0;
    stall = reset & read_en & ~byte_valid;
    pc = pc_q;
  end

  always_comb begin
    fifo_d = fifo_q;
    if (push) fifo_d[wr_q] = mem_data;
    // The discard address freezes on the request that was cut off.
    req_addr_d = (state_q == REQ) ? fetch_q : req_addr_q;
    if (flush) begin
      fetch_d = flush_addr;
      pc_d = flush_addr;
      rd_d = '0;
      wr_d = '0;
      cnt_d = '0;
    end else begin
      fetch_d = fetch_q + WORD_SIZE'(push);
      pc_d = pc_q + WORD_SIZE'(pop);
      rd_d = rd_q + PW'(pop);
      wr_d = wr_q + PW'(push);
      cnt_d = cnt_pop + CW'(push);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      pc_q <= RESET_PC;
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      fetch_q <= fetch_d;
      req_addr_q <= req_addr_d;
      pc_q <= pc_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
      fifo_q <= fifo_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit with an in-bench
// memory model and stream-level reference of the fetched bytes.
module tb_fetch_unit;
  localparam int DEPTH = 4;
  localparam logic [15:0] RPC = 16'h0000;

  logic clk = 0;
  logic reset = 0;
  logic mem_req, mem_ack = 0;
  logic [15:0] mem_addr;
  logic [7:0] mem_data = 0;
  logic read_en = 0;
  logic [7:0] ext_data_bus;
  logic byte_valid, stall;
  logic flush = 0;
  logic [15:0] flush_addr = 0;
  logic [15:0] pc;

  fetch_unit #(
    .BYTE_SIZE(8), .WORD_SIZE(16), .DEPTH(DEPTH), .RESET_PC(RPC)
  ) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_data(mem_data),
    .read_en(read_en), .ext_data_bus(ext_data_bus),
    .byte_valid(byte_valid), .stall(stall),
    .flush(flush), .flush_addr(flush_addr), .pc(pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0] data;
  } ent_t;

  ent_t exp_q[$];
  int tests = 0;
  int fails = 0;
  logic [15:0] ref_pc = RPC;
  logic [15:0] ref_fetch = RPC;
  bit discard = 0;
  bit exp_req = 0;
  bit mon_en = 0;
  bit prev_wait = 0;
  logic [15:0] prev_addr = 0;
  int wait_n = 0;
  int wcnt = 0;
  int p_read = 0;
  int p_flush = 0;
  bit rand_faddr = 0;
  logic [7:0] salt = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, expv, $time);
    end
  endtask

  // Monitor: compares registered outputs and consumes on pops.
  always begin
    @(negedge clk);
    #2;
    if (mon_en) begin
      chk("byte_valid", 32'(byte_valid), 32'(exp_q.size() != 0));
      chk("pc", 32'(pc), 32'(ref_pc));
      if (exp_q.size() != 0)
        chk("head_data", 32'(ext_data_bus), 32'(exp_q[0].data));
      else
        chk("empty_data", 32'(ext_data_bus), 32'(0));
      chk("stall", 32'(stall), 32'(read_en && exp_q.size() == 0));
      chk("mem_req", 32'(mem_req), 32'(exp_req));
      if (prev_wait && mem_req)
        chk("addr_hold", 32'(mem_addr), 32'(prev_addr));
      if (read_en && exp_q.size() != 0 && !flush) begin
        void'(exp_q.pop_front());
        ref_pc++;
      end
    end
  end

  task automatic cycle(input bit do_flush, input logic [15:0] faddr);
    bit acked, nreq;
    @(negedge clk);
    read_en = ($urandom_range(99) < p_read);
    flush = do_flush || ($urandom_range(99) < p_flush);
    if (rand_faddr)
      flush_addr = ($urandom_range(3) == 0) ?
                   16'hFFFC + 16'($urandom_range(3)) : 16'($urandom);
    else
      flush_addr = faddr;
    mem_ack = mem_req && (wcnt >= wait_n);
    mem_data = mem_ack ? mem_addr[7:0] + salt : 8'($urandom);
    #4;
    acked = mem_req && mem_ack;
    if (acked && !discard && !flush) begin
      chk("fetch_addr", 32'(mem_addr), 32'(ref_fetch));
      chk("no_overflow", 32'(exp_q.size() < DEPTH), 32'(1));
      exp_q.push_back('{ref_fetch, ref_fetch[7:0] + salt});
      ref_fetch++;
    end
    if (mem_req)
      nreq = mem_ack ? (!discard && !flush && exp_q.size() < DEPTH) : 1'b1;
    else
      nreq = !flush && exp_q.size() < DEPTH;
    if (acked) discard = 0;
    if (flush) begin
      if (mem_req && !mem_ack) discard = 1;
      exp_q.delete();
      ref_pc = flush_addr;
      ref_fetch = flush_addr;
    end
    if (mem_req) wcnt = mem_ack ? 0 : wcnt + 1;
    prev_wait = mem_req && !mem_ack;
    prev_addr = mem_addr;
    exp_req = nreq;
  endtask

  task automatic model_reset();
    exp_q.delete();
    ref_pc = RPC;
    ref_fetch = RPC;
    discard = 0;
    exp_req = 0;
    wcnt = 0;
    prev_wait = 0;
    mem_ack = 0;
    flush = 0;
  endtask

  task automatic reset_checks();
    chk("rst_mem_req", 32'(mem_req), 32'(0));
    chk("rst_mem_addr", 32'(mem_addr), 32'(RPC));
    chk("rst_pc", 32'(pc), 32'(RPC));
    chk("rst_valid", 32'(byte_valid), 32'(0));
    chk("rst_data", 32'(ext_data_bus), 32'(0));
    chk("rst_stall", 32'(stall), 32'(0));
  endtask

  initial begin
    bit found;
    read_en = 1;
    #1;
    reset_checks();
    read_en = 0;
    @(posedge clk);
    #1 reset = 1;
    mon_en = 1;

    // Fill with no consumer: requests stop once four bytes are held.
    p_read = 0; p_flush = 0; wait_n = 0;
    repeat (10) cycle(0, 0);
    chk("fill_count", 32'(exp_q.size()), 32'(DEPTH));

    p_read = 100;
    repeat (30) cycle(0, 0);

    wait_n = 3;
    repeat (40) cycle(0, 0);

    // Cut off the request to 0005 with a redirect to 0100.
    cycle(1, 16'h0000);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      cycle(0, 0);
      found = exp_req && !discard && ref_fetch == 16'h0005 && wcnt == 0;
    end
    chk("reach_req5", 32'(found), 32'(1));
    cycle(1, 16'h0100);
    @(posedge clk);
    #1;
    chk("discard_req", 32'({mem_req, mem_addr}), 32'({1'b1, 16'h0005}));
    chk("flush_pc", 32'(pc), 32'(16'h0100));
    chk("flush_empty", 32'(byte_valid), 32'(0));
    repeat (30) cycle(0, 0);

    wait_n = 0;
    cycle(1, 16'hFFFE);
    repeat (12) cycle(0, 0);

    // Asynchronous reset between edges while a request is pending.
    p_read = 0; wait_n = 2;
    cycle(1, 16'h0040);
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      cycle(0, 0);
      @(posedge clk);
      #1;
      found = exp_q.size() == 2 && exp_req && !discard;
    end
    chk("reach_two", 32'(found), 32'(1));
    mon_en = 0;
    read_en = 1;
    reset = 0;
    #1;
    reset_checks();
    model_reset();
    read_en = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1;
    mon_en = 1;
    wait_n = 0;
    repeat (10) cycle(0, 0);

    // Random traffic.
    rand_faddr = 1;
    p_flush = 4;
    for (int i = 0; i < 3000; i++) begin
      if (i % 100 == 0) begin
        wait_n = $urandom_range(3);
        p_read = $urandom_range(100);
        salt = 8'($urandom);
      end
      cycle(0, 0);
    end

    @(negedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
